// File: rtl/sort_receiver.sv
// Serial-to-parallel frame receiver that counts ones and flags truncated frames.
// Optional build macro SORT_RX_ORDER_CHECK_EN adds a thermometer-order violation check to err.
module sort_receiver #(
  parameter int N = 8
) (
  input  logic                     ck,
  input  logic                     reset,
  input  logic                     din,
  input  logic                     vi,
  output logic [N-1:0]             word,
  output logic [$clog2(N+1)-1:0]   count,
  output logic                     done,
  output logic                     err,
  output logic                     rdy
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   bpos;

  // Bit k of the frame lands MSB-first, so the write position counts down.
  assign bpos = LAST - idx;

`ifdef SORT_RX_ORDER_CHECK_EN
  logic seen_one;
  logic viol;
  logic viol_nxt;

  // A zero arriving after any one breaks the zeros-then-ones ordering.
  assign viol_nxt = viol | (seen_one & ~din);
`endif

  always_ff @(posedge ck) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      word  <= '0;
      count <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
      rdy   <= 1'b1;
`ifdef SORT_RX_ORDER_CHECK_EN
      seen_one <= 1'b0;
      viol     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (vi) begin
            state <= RECV;
            idx   <= IW'(1);
            word  <= {din, {(N-1){1'b0}}};
            count <= CW'(din);
            rdy   <= 1'b0;
`ifdef SORT_RX_ORDER_CHECK_EN
            seen_one <= din;
            viol     <= 1'b0;
`endif
          end else begin
            state <= IDLE;
            rdy   <= 1'b1;
          end
        end
        RECV: begin
          if (vi) begin
            word[bpos] <= din;
            count      <= count + CW'(din);
`ifdef SORT_RX_ORDER_CHECK_EN
            seen_one <= seen_one | din;
            viol     <= viol_nxt;
`endif
            if (idx == LAST) begin
              state <= DONE;
              idx   <= '0;
              done  <= 1'b1;
              rdy   <= 1'b1;
`ifdef SORT_RX_ORDER_CHECK_EN
              err   <= viol_nxt;
`else
              err   <= 1'b0;
`endif
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            // Frame cut short: keep the partial word/count, flag the error.
            state <= DONE;
            idx   <= '0;
            done  <= 1'b1;
            rdy   <= 1'b1;
            err   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          rdy   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_receiver.sv
// Self-checking bench for sort_receiver: frame-level reference model plus directed literal checks.
module tb_sort_receiver;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);
`ifdef SORT_RX_ORDER_CHECK_EN
  localparam bit ORDER = 1'b1;
`else
  localparam bit ORDER = 1'b0;
`endif

  logic          ck = 1'b0;
  logic          reset = 1'b0;
  logic          din = 1'b0;
  logic          vi = 1'b0;
  logic [N-1:0]  word;
  logic [CW-1:0] count;
  logic          done;
  logic          err;
  logic          rdy;

  sort_receiver #(.N(N)) dut (
    .ck(ck), .reset(reset), .din(din), .vi(vi),
    .word(word), .count(count), .done(done), .err(err), .rdy(rdy)
  );

  always #5 ck = ~ck;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge ck) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: collects each frame's bits and derives the outputs from the list.
  bit            inframe = 1'b0;
  bit            bits[$];
  bit            m_valid = 1'b0;
  logic [N-1:0]  m_word;
  logic [CW-1:0] m_count;
  logic          m_done, m_err, m_rdy;

  function automatic logic [N-1:0] f_word(input bit b[$]);
    logic [N-1:0] w = '0;
    for (int k = 0; k < b.size(); k++) w[N-1-k] = b[k];
    return w;
  endfunction

  function automatic int f_count(input bit b[$]);
    int c = 0;
    foreach (b[k]) c += int'(b[k]);
    return c;
  endfunction

  function automatic bit f_unsorted(input bit b[$]);
    for (int i = 0; i < b.size(); i++)
      for (int j = i + 1; j < b.size(); j++)
        if (b[i] && !b[j]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic close_frame(input bit trunc);
    m_word  = f_word(bits);
    m_count = CW'(f_count(bits));
    m_err   = trunc | (ORDER & f_unsorted(bits));
    m_done  = 1'b1;
    m_rdy   = 1'b1;
    inframe = 1'b0;
  endtask

  always @(posedge ck) begin
    if (!reset) begin
      inframe = 1'b0;
      bits.delete();
      m_word  = '0;
      m_count = '0;
      m_done  = 1'b0;
      m_err   = 1'b0;
      m_rdy   = 1'b1;
    end else begin
      m_done = 1'b0;
      m_err  = 1'b0;
      if (inframe) begin
        if (vi) begin
          bits.push_back(din);
          if (bits.size() == N) close_frame(1'b0);
        end else begin
          close_frame(1'b1);
        end
      end else if (vi) begin
        bits.delete();
        bits.push_back(din);
        inframe = 1'b1;
        m_rdy   = 1'b0;
      end else begin
        m_rdy = 1'b1;
      end
    end
    m_valid = 1'b1;
  end

  always @(negedge ck) begin
    if (m_valid) begin
      check("done", 32'(done), 32'(m_done));
      check("rdy",  32'(rdy),  32'(m_rdy));
      check("err",  32'(err),  32'(m_err));
      if (!inframe) begin
        check("word",  32'(word),  32'(m_word));
        check("count", 32'(count), 32'(m_count));
      end
    end
  end

  task automatic drive(input logic v, input logic d);
    vi  = v;
    din = d;
    @(posedge ck);
    #1;
  endtask

  task automatic send_frame(input logic [N-1:0] pat, input int len, input bit chk_rdy);
    for (int k = 0; k < len; k++) begin
      drive(1'b1, pat[N-1-k]);
      if (chk_rdy && k < len - 1) check("rdy_recv", 32'(rdy), 32'd0);
    end
  endtask

  task automatic expect_frame(input string name, input logic [N-1:0] w, input int c, input logic e);
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_word"}, 32'(word), 32'(w));
    check({name, "_count"}, 32'(count), 32'(c));
    check({name, "_err"}, 32'(err), 32'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] pat;
    logic [N-1:0] ones;
    int t1, len, gap;

    #1;
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    check("rst_word",  32'(word),  32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_err",   32'(err),   32'd0);
    check("rst_rdy",   32'(rdy),   32'd1);
    reset = 1'b1;
    drive(1'b0, 1'b0);

    send_frame(8'b00000111, N, 1'b1);
    expect_frame("thermo3", 8'b00000111, 3, 1'b0);
    check("thermo3_rdy", 32'(rdy), 32'd1);
    drive(1'b0, 1'b0);
    check("idle_done", 32'(done), 32'd0);

    send_frame(8'hFF, N, 1'b0);
    expect_frame("ones", 8'hFF, 8, 1'b0);
    drive(1'b0, 1'b0);
    send_frame(8'h00, N, 1'b0);
    expect_frame("zeros", 8'h00, 0, 1'b0);
    drive(1'b0, 1'b0);

    send_frame(8'b01011111, N, 1'b0);
    expect_frame("unsorted", 8'b01011111, 6, ORDER);
    drive(1'b0, 1'b0);

    send_frame(8'b11111000, 5, 1'b0);
    drive(1'b0, 1'b0);
    expect_frame("trunc5", 8'b11111000, 5, 1'b1);
    drive(1'b0, 1'b0);

    send_frame(8'b00111111, N, 1'b0);
    expect_frame("b2b_a", 8'b00111111, 6, 1'b0);
    t1 = cyc;
    send_frame(8'b00000001, N, 1'b0);
    expect_frame("b2b_b", 8'b00000001, 1, 1'b0);
    check("b2b_gap", 32'(cyc - t1), 32'(N));
    drive(1'b0, 1'b0);

    send_frame(8'b00001000, 5, 1'b0);
    reset = 1'b0;
    drive(1'b1, 1'b1);
    check("mid_rst_word",  32'(word),  32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_done",  32'(done),  32'd0);
    check("mid_rst_rdy",   32'(rdy),   32'd1);
    drive(1'b1, 1'b1);
    reset = 1'b1;
    drive(1'b0, 1'b0);
    check("post_rst_done", 32'(done), 32'd0);
    send_frame(8'b00011111, N, 1'b0);
    expect_frame("post_rst", 8'b00011111, 5, 1'b0);
    drive(1'b0, 1'b0);

    ones = '1;
    for (int f = 0; f < 80; f++) begin
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N - 1)) : N;
      if ($urandom_range(0, 1) == 1) pat = ones >> $urandom_range(0, N);
      else pat = N'($urandom);
      send_frame(pat, len, 1'b0);
      gap = int'($urandom_range(0, 2));
      if (len < N && gap == 0) gap = 1;
      for (int g = 0; g < gap; g++) drive(1'b0, 1'b0);
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b0;
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        reset = 1'b1;
      end
    end
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
